sram_controller: RTL



---
 rtl/sram_controller_pkg.sv | 35 +++
 rtl/sram_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sram_controller_pkg.sv
// sram_ctrl_pkg: shared types and constants for the external 16-bit SRAM
// controller.
//   state_t          : access sequencer states (IDLE/LOW/HIGH/DONE)
//   SRAM_DATA_W      : SRAM data bus width (16)
//   SRAM_ADDR_W      : SRAM half-word address width (18)
//   WORD_IDX_W       : 32-bit word index width (17)
//   DEFAULT_BASE_ADDR: processor byte address of SRAM half-word 0
//   ADDR_RANGE_LIMIT : size in bytes of the SRAM window seen by the processor
//   word_index()     : byte address -> SRAM word index (wraps modulo 2^17)
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned WORD_IDX_W  = SRAM_ADDR_W - 1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam logic [31:0] ADDR_RANGE_LIMIT  = 32'h80000;

  function automatic logic [WORD_IDX_W-1:0] word_index(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    logic [31:0] offset;
    offset = addr - base;
    return offset[WORD_IDX_W+1:2];
  endfunction

endpackage

// File: rtl/sram_controller.sv
// sram_controller: memory-stage initiator for the external 16-bit async SRAM.
// Each 32-bit read/write request becomes two SRAM bus cycles (low half then
// high half), each held for ACCESS_CYCLES clocks, followed by one DONE clock.
//
// Parameters:
//   ACCESS_CYCLES : clocks per half-word phase (>= 1)
//   BASE_ADDR     : processor byte address mapping to SRAM half-word 0
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rd_en, wr_en    : word request (held until ready); write wins
//   address         : byte address, bits [1:0] ignored
//   write_data      : store data
//   read_data       : last completed read word
//   ready           : no request pending or access completes this cycle
//   err             : out-of-range flag, high during DONE only
//   sram_dq         : bidirectional SRAM data, Z unless writing
//   sram_addr       : SRAM half-word address
//   sram_*_n        : active-low SRAM controls
//
// Build option: define SRAM_ADDR_CHECK_EN to reject requests outside the
// SRAM window (they skip the bus and raise err); otherwise err is 0 and
// addresses wrap modulo 2^17 words.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic                   err,
  inout  wire  [SRAM_DATA_W-1:0] sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_IDX_W-1:0]  word_q;
  logic [31:0]            wdata_q;
  logic                   is_write_q;
  logic                   accept;
  logic                   req;
  logic                   phase_last;
  logic                   in_phase;
  logic                   drive_dq;
  logic                   oor_req;

  assign req        = rd_en | wr_en;
  assign phase_last = (cnt_q == CNT_LAST);

`ifdef SRAM_ADDR_CHECK_EN
  logic oor_q;

  assign oor_req = (address < BASE_ADDR) ||
                   ((address - BASE_ADDR) >= ADDR_RANGE_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      oor_q <= 1'b0;
    end else if (accept) begin
      oor_q <= oor_req;
    end
  end

  assign err = (state_q == ST_DONE) & oor_q;
`else
  assign oor_req = 1'b0;
  assign err     = 1'b0;
`endif

  // Next-state and phase counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req) begin
          accept  = 1'b1;
          state_d = oor_req ? ST_DONE : ST_LOW;
        end
      end
      ST_LOW: begin
        if (phase_last) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      read_data  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        word_q     <= word_index(address, BASE_ADDR);
        wdata_q    <= write_data;
        is_write_q <= wr_en;
      end
      // Read data is sampled on the final clock of each phase so the SRAM
      // has had the full ACCESS_CYCLES window to settle.
      if (!is_write_q && phase_last) begin
        if (state_q == ST_LOW) begin
          read_data[15:0] <= sram_dq;
        end
        if (state_q == ST_HIGH) begin
          read_data[31:16] <= sram_dq;
        end
      end
    end
  end

  // Bus controls decoded only from registered state
  assign in_phase  = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign drive_dq  = in_phase & is_write_q;

  assign sram_ce_n = ~in_phase;
  assign sram_ub_n = ~in_phase;
  assign sram_lb_n = ~in_phase;
  assign sram_we_n = ~(in_phase & is_write_q);
  assign sram_oe_n = ~(in_phase & ~is_write_q);
  assign sram_addr = {word_q, (state_q == ST_HIGH)};

  assign sram_dq = drive_dq ? ((state_q == ST_HIGH) ? wdata_q[31:16] : wdata_q[15:0])
                            : 'z;

  assign ready = ~req | (state_q == ST_DONE);

endmodule
